// File: rtl/gb_pulsecontrol.sv
`default_nettype none
// ============================================================================
//  Module   : gb_pulsecontrol
//  Purpose  : Control front end for one APU pulse channel. Decodes CPU byte
//             reads/writes of NR10..NR14, holds the configuration fields that
//             feed the pulse channel, generates the one-cycle trigger pulse
//             and runs the 512 Hz frame sequencer (length/envelope/sweep).
//  Ports    : clk, reset (sync, active-high), apu_on (NR52 power),
//             div_apu_tick (512 Hz strobe), wr_en/rd_en/addr/wdata/rdata
//             (register bus), enable -> ch_active (status mirror),
//             clk_length_ctr/clk_vol_env/clk_sweep (tick strobes),
//             NR10..NR14 decoded fields, start (trigger pulse).
//  Options  : define GB_PULSE_SWEEP_EN to implement NR10 and clk_sweep
//             (channel 1). Left undefined, NR10 is absent and reads 0xFF
//             (channel 2).
//  Revision : 1.0 - initial release
// ============================================================================
module gb_pulsecontrol (
    input  logic        clk,
    input  logic        reset,
    input  logic        apu_on,
    input  logic        div_apu_tick,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    input  logic        enable,
    output logic        ch_active,
    output logic        clk_length_ctr,
    output logic        clk_vol_env,
    output logic        clk_sweep,
    output logic [2:0]  sweep_time,
    output logic        sweep_decreasing,
    output logic [2:0]  num_sweep_shifts,
    output logic [1:0]  wave_duty,
    output logic [5:0]  length,
    output logic [3:0]  initial_volume,
    output logic        envelope_increasing,
    output logic [2:0]  num_envelope_sweeps,
    output logic [10:0] frequency,
    output logic        single,
    output logic        start
);

    localparam logic [2:0] c_NR10 = 3'd0;
    localparam logic [2:0] c_NR11 = 3'd1;
    localparam logic [2:0] c_NR12 = 3'd2;
    localparam logic [2:0] c_NR13 = 3'd3;
    localparam logic [2:0] c_NR14 = 3'd4;

    // Register file
`ifdef GB_PULSE_SWEEP_EN
    logic [6:0] nr10_q, nr10_d;
    logic       sweep_q, sweep_d;
`endif
    logic [7:0] nr11_q, nr11_d;
    logic [7:0] nr12_q, nr12_d;
    logic [7:0] nr13_q, nr13_d;
    logic       nr14_len_q, nr14_len_d;
    logic [2:0] nr14_freq_q, nr14_freq_d;

    // Pulses, sequencer, bus
    logic       start_q, start_d;
    logic [2:0] step_q, step_d;
    logic       len_q, len_d;
    logic       env_q, env_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ch_active_q;
    logic [7:0] w_rd_mux;

    // Read mux: unimplemented bits read back as 1. Uses current register
    // contents, so a same-cycle write is not visible to the read.
    always_comb begin
        w_rd_mux = 8'hFF;
        case (addr)
`ifdef GB_PULSE_SWEEP_EN
            c_NR10:  w_rd_mux = {1'b1, nr10_q};
`else
            c_NR10:  w_rd_mux = 8'hFF;
`endif
            c_NR11:  w_rd_mux = nr11_q | 8'h3F;
            c_NR12:  w_rd_mux = nr12_q;
            c_NR13:  w_rd_mux = 8'hFF;
            c_NR14:  w_rd_mux = {1'b1, nr14_len_q, 6'h3F};
            default: w_rd_mux = 8'hFF;
        endcase
    end

    // Next-state logic
    always_comb begin
`ifdef GB_PULSE_SWEEP_EN
        nr10_d      = nr10_q;
        sweep_d     = 1'b0;
`endif
        nr11_d      = nr11_q;
        nr12_d      = nr12_q;
        nr13_d      = nr13_q;
        nr14_len_d  = nr14_len_q;
        nr14_freq_d = nr14_freq_q;
        step_d      = step_q;
        start_d     = 1'b0;
        len_d       = 1'b0;
        env_d       = 1'b0;
        rdata_d     = rdata_q;

        // Reads stay live while powered off; they see the cleared registers.
        if (rd_en) begin
            rdata_d = w_rd_mux;
        end

        if (!apu_on) begin
`ifdef GB_PULSE_SWEEP_EN
            nr10_d      = 7'd0;
`endif
            nr11_d      = 8'd0;
            nr12_d      = 8'd0;
            nr13_d      = 8'd0;
            nr14_len_d  = 1'b0;
            nr14_freq_d = 3'd0;
            step_d      = 3'd0;
        end else begin
            if (wr_en) begin
                case (addr)
`ifdef GB_PULSE_SWEEP_EN
                    c_NR10: nr10_d = wdata[6:0];
`endif
                    c_NR11: nr11_d = wdata;
                    c_NR12: nr12_d = wdata;
                    c_NR13: nr13_d = wdata;
                    c_NR14: begin
                        nr14_len_d  = wdata[6];
                        nr14_freq_d = wdata[2:0];
                        start_d     = wdata[7];  // trigger bit, not stored
                    end
                    default: ;
                endcase
            end

            // Strobes decode the step before it advances.
            if (div_apu_tick) begin
                step_d = step_q + 3'd1;
                len_d  = ~step_q[0];
                env_d  = (step_q == 3'd7);
`ifdef GB_PULSE_SWEEP_EN
                sweep_d = (step_q[1:0] == 2'b10);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef GB_PULSE_SWEEP_EN
            nr10_q      <= 7'd0;
            sweep_q     <= 1'b0;
`endif
            nr11_q      <= 8'd0;
            nr12_q      <= 8'd0;
            nr13_q      <= 8'd0;
            nr14_len_q  <= 1'b0;
            nr14_freq_q <= 3'd0;
            step_q      <= 3'd0;
            start_q     <= 1'b0;
            len_q       <= 1'b0;
            env_q       <= 1'b0;
            rdata_q     <= 8'd0;
            ch_active_q <= 1'b0;
        end else begin
`ifdef GB_PULSE_SWEEP_EN
            nr10_q      <= nr10_d;
            sweep_q     <= sweep_d;
`endif
            nr11_q      <= nr11_d;
            nr12_q      <= nr12_d;
            nr13_q      <= nr13_d;
            nr14_len_q  <= nr14_len_d;
            nr14_freq_q <= nr14_freq_d;
            step_q      <= step_d;
            start_q     <= start_d;
            len_q       <= len_d;
            env_q       <= env_d;
            rdata_q     <= rdata_d;
            ch_active_q <= enable;
        end
    end

    // Outputs
`ifdef GB_PULSE_SWEEP_EN
    assign sweep_time       = nr10_q[6:4];
    assign sweep_decreasing = nr10_q[3];
    assign num_sweep_shifts = nr10_q[2:0];
    assign clk_sweep        = sweep_q;
`else
    assign sweep_time       = 3'd0;
    assign sweep_decreasing = 1'b0;
    assign num_sweep_shifts = 3'd0;
    assign clk_sweep        = 1'b0;
`endif
    assign wave_duty           = nr11_q[7:6];
    assign length              = nr11_q[5:0];
    assign initial_volume      = nr12_q[7:4];
    assign envelope_increasing = nr12_q[3];
    assign num_envelope_sweeps = nr12_q[2:0];
    assign frequency           = {nr14_freq_q, nr13_q};
    assign single              = nr14_len_q;
    assign start               = start_q;
    assign clk_length_ctr      = len_q;
    assign clk_vol_env         = env_q;
    assign rdata               = rdata_q;
    assign ch_active           = ch_active_q;

endmodule
`default_nettype wire

// File: tb/tb_gb_pulsecontrol.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gb_pulsecontrol
//  Purpose  : Self-checking bench for gb_pulsecontrol. A behavioural model of
//             the register map and frame sequencer is compared with the DUT
//             on every falling edge; directed steps add literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gb_pulsecontrol;

`ifdef GB_PULSE_SWEEP_EN
    localparam bit SWEEP_EN = 1'b1;
`else
    localparam bit SWEEP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, apu_on, div_apu_tick, wr_en, rd_en, enable;
    logic [2:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ch_active, clk_length_ctr, clk_vol_env, clk_sweep;
    logic [2:0]  sweep_time, num_sweep_shifts, num_envelope_sweeps;
    logic        sweep_decreasing, envelope_increasing, single, start;
    logic [1:0]  wave_duty;
    logic [5:0]  length;
    logic [3:0]  initial_volume;
    logic [10:0] frequency;

    gb_pulsecontrol dut (
        .clk(clk), .reset(reset), .apu_on(apu_on), .div_apu_tick(div_apu_tick),
        .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata), .rdata(rdata),
        .enable(enable), .ch_active(ch_active),
        .clk_length_ctr(clk_length_ctr), .clk_vol_env(clk_vol_env), .clk_sweep(clk_sweep),
        .sweep_time(sweep_time), .sweep_decreasing(sweep_decreasing),
        .num_sweep_shifts(num_sweep_shifts), .wave_duty(wave_duty), .length(length),
        .initial_volume(initial_volume), .envelope_increasing(envelope_increasing),
        .num_envelope_sweeps(num_envelope_sweeps), .frequency(frequency),
        .single(single), .start(start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m [0:4];   // bits the register map keeps, per address
    int         mstep;
    logic       e_start, e_len, e_env, e_sweep, e_act;
    logic [7:0] e_rdata;
    bit         started = 1'b0;

    function automatic logic [7:0] keep_mask(input int a);
        case (a)
            0: return SWEEP_EN ? 8'h7F : 8'h00;
            4: return 8'h47;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] read_value(input int a);
        case (a)
            0: return SWEEP_EN ? (m[0] | 8'h80) : 8'hFF;
            1: return m[1] | 8'h3F;
            2: return m[2];
            3: return 8'hFF;
            4: return m[4] | 8'hBF;
            default: return 8'hFF;
        endcase
    endfunction

    always @(posedge clk) begin
        started = 1'b1;
        e_start = 1'b0; e_len = 1'b0; e_env = 1'b0; e_sweep = 1'b0;
        if (reset) begin
            for (int i = 0; i < 5; i++) m[i] = 8'h00;
            mstep = 0; e_rdata = 8'h00; e_act = 1'b0;
        end else begin
            e_act = enable;
            if (rd_en) e_rdata = read_value(int'(addr));
            if (!apu_on) begin
                for (int i = 0; i < 5; i++) m[i] = 8'h00;
                mstep = 0;
            end else begin
                if (wr_en && addr < 5) m[addr] = wdata & keep_mask(int'(addr));
                if (wr_en && addr == 4 && wdata[7]) e_start = 1'b1;
                if (div_apu_tick) begin
                    e_len   = (mstep % 2 == 0);
                    e_sweep = SWEEP_EN && (mstep % 4 == 2);
                    e_env   = (mstep == 7);
                    mstep   = (mstep + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("cfg",
                  {sweep_time, sweep_decreasing, num_sweep_shifts, wave_duty, length,
                   initial_volume, envelope_increasing, num_envelope_sweeps, frequency, single},
                  {m[0][6:0], m[1], m[2], m[4][2:0], m[3], m[4][6]});
            check("rdata", rdata, e_rdata);
            check("pulses", {start, clk_length_ctr, clk_vol_env, clk_sweep, ch_active},
                  {e_start, e_len, e_env, e_sweep, e_act});
        end
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] len_at   = 8'h55;
    logic [7:0] env_at   = 8'h80;
    logic [7:0] sweep_at = SWEEP_EN ? 8'h44 : 8'h00;
    int n_len = 0;

    task automatic tick_and_check(input int stp);
        @(negedge clk); div_apu_tick = 1'b1;
        @(negedge clk); div_apu_tick = 1'b0;
        check("len_step", clk_length_ctr, len_at[stp]);
        check("env_step", clk_vol_env, env_at[stp]);
        check("sweep_step", clk_sweep, sweep_at[stp]);
        if (clk_length_ctr) n_len++;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk); wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk); rd_en = 1'b1; addr = a;
        @(negedge clk); rd_en = 1'b0;
        check("read", rdata, exp);
    endtask

    initial begin
        reset = 1'b1; apu_on = 1'b1; div_apu_tick = 1'b0; wr_en = 1'b0;
        rd_en = 1'b0; enable = 1'b0; addr = 3'd0; wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 8'h00);
        check("rst_start", start, 1'b0);
        check("rst_freq", frequency, 11'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Frame sequencer: one full lap plus the wrap back to step 0
        for (int k = 0; k < 8; k++) begin
            tick_and_check(k);
            repeat (62) @(negedge clk);
        end
        check("len_count", n_len, 4);
        tick_and_check(0);
        check("ch_active", ch_active, 1'b1);

        // Configuration writes and trigger
        wr(3'd1, 8'h81);
        wr(3'd2, 8'h1F);
        wr(3'd3, 8'hFF);
        wr(3'd4, 8'hC7);
        check("start_hi", start, 1'b1);
        check("duty", wave_duty, 2'd2);
        check("length", length, 6'd1);
        check("vol", initial_volume, 4'd1);
        check("env_inc", envelope_increasing, 1'b1);
        check("env_n", num_envelope_sweeps, 3'd7);
        check("freq", frequency, 11'h7FF);
        check("single", single, 1'b1);
        @(negedge clk);
        check("start_lo", start, 1'b0);

        // Read-back masks
        wr(3'd0, 8'h7F);
        check("sweep_time", sweep_time, SWEEP_EN ? 3'd7 : 3'd0);
        rd(3'd0, 8'hFF);
        rd(3'd1, 8'hBF);
        rd(3'd2, 8'h1F);
        rd(3'd3, 8'hFF);
        rd(3'd4, 8'hFF);
        rd(3'd6, 8'hFF);

        // Bring step back to 0 (currently 1), then trigger with a tick
        for (int k = 1; k < 8; k++) tick_and_check(k);
        @(negedge clk); wr_en = 1'b1; addr = 3'd4; wdata = 8'h80; div_apu_tick = 1'b1;
        @(negedge clk); wr_en = 1'b0; div_apu_tick = 1'b0;
        check("trig_start", start, 1'b1);
        check("trig_len", clk_length_ctr, 1'b1);

        // Same-cycle write and read: read returns the old value
        @(negedge clk); wr_en = 1'b1; rd_en = 1'b1; addr = 3'd2; wdata = 8'h55;
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
        check("rw_old", rdata, 8'h1F);
        check("rw_new", initial_volume, 4'd5);

        // Reset coinciding with a trigger write cancels the pulse
        @(negedge clk); reset = 1'b1; wr_en = 1'b1; addr = 3'd4; wdata = 8'h87;
        @(negedge clk); reset = 1'b0; wr_en = 1'b0;
        check("rst_cancel", start, 1'b0);
        check("rst_freq2", frequency, 11'd0);

        // Power off: contents cleared, writes and ticks ignored
        wr(3'd2, 8'hA3);
        wr(3'd1, 8'h40);
        tick_and_check(0);
        @(negedge clk); apu_on = 1'b0;
        wr(3'd2, 8'hF0);
        check("off_vol", initial_volume, 4'd0);
        check("off_duty", wave_duty, 2'd0);
        rd(3'd2, 8'h00);
        rd(3'd1, 8'h3F);
        @(negedge clk); div_apu_tick = 1'b1;
        @(negedge clk); div_apu_tick = 1'b0;
        check("off_strobes", {clk_length_ctr, clk_vol_env, clk_sweep}, 3'b000);
        @(negedge clk); apu_on = 1'b1;
        tick_and_check(0);
        tick_and_check(1);

        // Sweep register through step 2
        wr(3'd0, 8'h7F);
        check("sweep_fields", {sweep_time, sweep_decreasing, num_sweep_shifts},
              SWEEP_EN ? 7'h7F : 7'h00);
        tick_and_check(2);
        rd(3'd0, 8'hFF);

        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("ch_inactive", ch_active, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gb_pulsecontrol.md
# gb_pulseControl

Control front end for one APU pulse channel. Decodes CPU byte writes/reads to the five pulse registers (NR10–NR14), holds the decoded configuration fields that drive the channel's static inputs, issues the one-cycle trigger pulse, and runs the 512 Hz frame sequencer that produces the length, envelope and sweep tick strobes. Sits between the APU bus decoder and `gb_pulseChannel`, driving every channel input except `clk` and `reset`.

## Interface
Parameters: none.

Ports:
- `clk` in 1 — system clock.
- `reset` in 1 — synchronous, active-high reset.
- `apu_on` in 1 — NR52 power bit; low clears and holds all state.
- `div_apu_tick` in 1 — one-cycle 512 Hz strobe from DIV.
- `wr_en` in 1 — register write strobe.
- `rd_en` in 1 — register read strobe.
- `addr` in 3 — 0..4 select NR10..NR14; 5..7 unmapped.
- `wdata` in 8 — write data.
- `rdata` out 8 — registered read data.
- `enable` in 1 — channel-active status from the channel, mirrored for NR52.
- `ch_active` out 1 — registered copy of `enable`.
- `clk_length_ctr`, `clk_vol_env`, `clk_sweep` out 1 each — one-cycle tick strobes.
- `sweep_time` out 3, `sweep_decreasing` out 1, `num_sweep_shifts` out 3 — NR10[6:4], [3], [2:0].
- `wave_duty` out 2, `length` out 6 — NR11[7:6], [5:0].
- `initial_volume` out 4, `envelope_increasing` out 1, `num_envelope_sweeps` out 3 — NR12[7:4], [3], [2:0].
- `frequency` out 11 — {NR14[2:0], NR13[7:0]}.
- `single` out 1 — NR14[6] length enable.
- `start` out 1 — one-cycle trigger pulse.

## Operation
- Register file: NR10 (7 bits), NR11, NR12, NR13 (8 bits), NR14 stored bits [6] and [2:0]. Config outputs are direct register fields, valid the cycle after the write.
- Write: `wr_en` with `apu_on`=1 updates the addressed register at the clock edge; unmapped addresses ignored. NR14 write with `wdata[7]`=1 asserts `start` for exactly the next cycle; bit 7 is not stored.
- Read: `rd_en` latches `rdata` next cycle with masks: NR10 = reg | 0x80; NR11 = reg | 0x3F; NR12 = reg; NR13 = 0xFF; NR14 = reg | 0xBF; addr 5..7 = 0xFF. `rdata` holds its value when `rd_en`=0.
- Frame sequencer: 3-bit `step`, advances (mod 8, 7→0 wrap) on each `div_apu_tick`. Strobes fire for the pre-increment step: length on 0,2,4,6; sweep on 2,6; envelope on 7.
- `apu_on`=0: all registers, `step`, strobes and `start` forced to 0; writes ignored; reads still return masked (zero-content) values; `div_apu_tick` ignored.

## Timing
- Reset values: all config outputs 0, `start`=0, all strobes 0, `step`=0, `rdata`=0x00, `ch_active`=0.
- Write→field: 1 cycle. NR14 trigger write at edge N → `start` high cycle N+1 only, config from the same write already visible in N+1.
- Read latency 1 cycle; simultaneous write and read to the same address returns the pre-write value.
- `div_apu_tick` at edge N → strobe(s) high cycle N+1 for one cycle; back-to-back ticks give back-to-back strobes.
- Trigger and tick in the same cycle are independent; both outputs assert in N+1.
- `reset` or `apu_on` falling mid-operation takes effect at the next edge; a pending `start` or strobe is cancelled.

## Configuration
- `GB_PULSE_SWEEP_EN` defined: NR10 implemented, `clk_sweep` generated as above (channel 1).
- Undefined: NR10 not stored, writes ignored, NR10 reads 0xFF, `sweep_time`/`sweep_decreasing`/`num_sweep_shifts`/`clk_sweep` tied 0 (channel 2).

## Test plan
- Reset, `apu_on`=1, 8 `div_apu_tick` pulses 64 cycles apart → length strobes at steps 0,2,4,6 (4 total), sweep at 2,6, envelope at 7; 9th tick → length strobe (wrap to 0).
- Write NR11=0x81, NR12=0x1F, NR13=0xFF, NR14=0xC7 → `wave_duty`=2, `length`=1, `initial_volume`=1, `envelope_increasing`=1, `num_envelope_sweeps`=7, `frequency`=0x7FF, `single`=1, `start` high exactly one cycle.
- Read back NR10..NR14 and addr 6 after above plus NR10=0x7F → 0xFF, 0xBF, 0x1F, 0xFF, 0xFF, 0xFF.
- NR14 trigger write coincident with `div_apu_tick` at step 0 → `start` and `clk_length_ctr` both high in the following cycle.
- Drop `apu_on` after configuring, write NR12=0xF0 → all fields 0, NR12 reads 0x00, ticks produce no strobes; raise `apu_on`, tick → step restarts at 0.
- Build without `GB_PULSE_SWEEP_EN`, write NR10=0x7F, tick through step 2 → NR10 reads 0xFF, sweep fields 0, `clk_sweep` never asserts.
